// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Raises o_miss to stall the pipeline while a line is evicted or refilled over a whole-line req/gnt port.
module data_cache_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 6
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_rd_req,
  input  logic                                  i_wr_req,
  input  logic [31:0]                           i_addr,
  input  logic [31:0]                           i_wr_data,
  output logic [31:0]                           o_rd_data,
  output logic                                  o_miss,
  output logic                                  o_mem_rd_req,
  output logic                                  o_mem_wr_req,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]  o_mem_addr,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]      o_mem_wr_line,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      i_mem_rd_line,
  input  logic                                  i_mem_gnt
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int SETS      = 1 << SET_ADDR_LEN;
  localparam int MEM_AW    = TAG_ADDR_LEN + SET_ADDR_LEN;
  localparam int SET_LSB   = LINE_ADDR_LEN + 2;
  localparam int TAG_LSB   = SET_LSB + SET_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
  typedef logic [LINE_SIZE-1:0][31:0] line_t;

  state_t                  r_state, w_next;
  logic [SETS-1:0]         r_valid, r_dirty;
  logic [TAG_ADDR_LEN-1:0] r_tag [SETS];
  line_t                   r_data [SETS];
  line_t                   r_line_buf, r_mem_wr_line;
  logic [31:0]             r_rd_data;
  logic                    r_mem_rd_req, r_mem_wr_req;
  logic [MEM_AW-1:0]       r_mem_addr;

  logic [LINE_ADDR_LEN-1:0] w_word;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [TAG_ADDR_LEN-1:0]  w_tag;
  logic w_req, w_hit, w_rd_hit, w_wr_hit, w_unused;

  assign w_word   = i_addr[SET_LSB-1:2];
  assign w_set    = i_addr[SET_LSB +: SET_ADDR_LEN];
  assign w_tag    = i_addr[TAG_LSB +: TAG_ADDR_LEN];
  assign w_unused = ^{i_addr[31:TAG_LSB+TAG_ADDR_LEN], i_addr[1:0]};
  assign w_req    = i_rd_req | i_wr_req;
  assign w_hit    = r_valid[w_set] && (r_tag[w_set] == w_tag);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_rd_hit = 1'b0;
    w_wr_hit = 1'b0;
    o_miss   = w_req && ((r_state != IDLE) || !w_hit);
    case (r_state)
      IDLE: if (w_req) begin
        if (w_hit) begin
          // store wins when both strobes are up
          w_wr_hit = i_wr_req;
          w_rd_hit = !i_wr_req;
        end else begin
          w_next = (r_valid[w_set] && r_dirty[w_set]) ? SWAP_OUT : SWAP_IN;
        end
      end
      SWAP_OUT:   if (i_mem_gnt) w_next = SWAP_IN;
      SWAP_IN:    if (i_mem_gnt) w_next = SWAP_IN_OK;
      SWAP_IN_OK: w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= '0;
      r_dirty       <= '0;
      r_rd_data     <= '0;
      r_mem_rd_req  <= 1'b0;
      r_mem_wr_req  <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_line <= '0;
    end else begin
      if (w_rd_hit) r_rd_data <= r_data[w_set][w_word];
      if (w_wr_hit) r_dirty[w_set] <= 1'b1;
      if (r_state == IDLE && w_next == SWAP_OUT) begin
        r_mem_wr_req  <= 1'b1;
        r_mem_addr    <= {r_tag[w_set], w_set};
        r_mem_wr_line <= r_data[w_set];
      end
      // refill request starts on entry to SWAP_IN, from IDLE or after the write-back grant
      if (r_state != SWAP_IN && w_next == SWAP_IN) begin
        r_mem_wr_req <= 1'b0;
        r_mem_rd_req <= 1'b1;
        r_mem_addr   <= {w_tag, w_set};
      end
      if (r_state == SWAP_IN && i_mem_gnt) r_mem_rd_req <= 1'b0;
      if (r_state == SWAP_IN_OK) begin
        r_valid[w_set] <= 1'b1;
        r_dirty[w_set] <= 1'b0;
      end
    end
  end

  // data/tag arrays need no reset: valid bits gate every use
  always_ff @(posedge i_clk) begin
    if (w_wr_hit) r_data[w_set][w_word] <= i_wr_data;
    if (r_state == SWAP_IN && i_mem_gnt) r_line_buf <= i_mem_rd_line;
    if (r_state == SWAP_IN_OK) begin
      r_data[w_set] <= r_line_buf;
      r_tag[w_set]  <= w_tag;
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_mem_rd_req  = r_mem_rd_req;
  assign o_mem_wr_req  = r_mem_wr_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_line = r_mem_wr_line;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: stimulus pushes expected events, a monitor pops and compares.
module tb_data_cache_ctrl;
  logic         clk, rst_n;
  logic         rd_req, wr_req;
  logic [31:0]  addr, wr_data, rd_data;
  logic         miss, mem_rd_req, mem_wr_req, mem_gnt;
  logic [7:0]   mem_addr;
  logic [255:0] mem_wr_line, mem_rd_line;

  data_cache_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_wr_req(wr_req),
    .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd_data), .o_miss(miss),
    .o_mem_rd_req(mem_rd_req), .o_mem_wr_req(mem_wr_req), .o_mem_addr(mem_addr),
    .o_mem_wr_line(mem_wr_line), .i_mem_rd_line(mem_rd_line), .i_mem_gnt(mem_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = rd_data after a read hit, 1 = write-back request, 2 = refill request
  typedef struct {int kind; logic [31:0] a; logic [31:0] d0; logic [31:0] d1;} ev_t;
  ev_t q[$];
  int n_chk = 0, n_fail = 0;
  int gnt_dly = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // memory model: refill word i of line la is A000_0000 | la<<8 | i
  initial begin
    int cnt;
    cnt = 0; mem_gnt = 1'b0; mem_rd_line = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_gnt) mem_gnt = 1'b0;
      else if (mem_rd_req || mem_wr_req) begin
        cnt++;
        if (cnt >= gnt_dly) begin
          cnt = 0;
          mem_gnt = 1'b1;
          for (int i = 0; i < 8; i++)
            mem_rd_line[32*i +: 32] = 32'hA000_0000 | (32'(mem_addr) << 8) | 32'(i);
        end
      end else cnt = 0;
    end
  end

  // monitor
  initial begin
    bit p_hit, p_rd, p_wr;
    ev_t e;
    p_hit = 0; p_rd = 0; p_wr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin p_hit = 0; p_rd = 0; p_wr = 0; continue; end
      if (p_hit) begin
        if (q.size() == 0) chk("unexpected_rd_data", 32'd0, 32'd1);
        else begin e = q.pop_front(); chk("rd_event_kind", 32'd0, 32'(e.kind)); chk("rd_data", rd_data, e.d0); end
      end
      p_hit = rd_req && !wr_req && !miss;
      if (mem_wr_req && !p_wr) begin
        if (q.size() == 0) chk("unexpected_mem_wr", 32'd0, 32'd1);
        else begin
          e = q.pop_front();
          chk("wr_event_kind", 32'd1, 32'(e.kind));
          chk("mem_wr_addr", 32'(mem_addr), e.a);
          chk("mem_wr_line_w0", mem_wr_line[31:0], e.d0);
          chk("mem_wr_line_w1", mem_wr_line[63:32], e.d1);
        end
      end
      if (mem_rd_req && !p_rd) begin
        if (q.size() == 0) chk("unexpected_mem_rd", 32'd0, 32'd1);
        else begin e = q.pop_front(); chk("rd_req_kind", 32'd2, 32'(e.kind)); chk("mem_rd_addr", 32'(mem_addr), e.a); end
      end
      p_wr = mem_wr_req;
      p_rd = mem_rd_req;
      if (mem_rd_req && mem_wr_req) chk("both_mem_reqs", 32'd1, 32'd0);
    end
  end

  function automatic ev_t ev(input int k, input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1);
    ev_t e; e.kind = k; e.a = a; e.d0 = d0; e.d1 = d1; return e;
  endfunction

  task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int exp_miss, input string name);
    int n;
    @(posedge clk); #1;
    rd_req = r; wr_req = w; addr = a; wr_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (!miss) break;
      n++;
      if (n > 60) break;
    end
    chk(name, 32'(n), 32'(exp_miss));
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0;
  endtask

  initial begin
    rst_n = 0; rd_req = 0; wr_req = 0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_mem_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wr_line", mem_wr_line[31:0] | mem_wr_line[255:224], 32'h0);

    // cold miss, grant in cycle 3
    q.push_back(ev(2, 32'h02, 0, 0));
    q.push_back(ev(0, 0, 32'hA000_0200, 0));
    do_req(1, 0, 32'h40, 0, 5, "miss_cycles_cold");

    // resident line: store, then loads
    do_req(0, 1, 32'h44, 32'hDEADBEEF, 0, "miss_cycles_wr_hit");
    q.push_back(ev(0, 0, 32'hDEADBEEF, 0));
    do_req(1, 0, 32'h44, 0, 0, "miss_cycles_rd_hit");
    q.push_back(ev(0, 0, 32'hA000_0207, 0));
    do_req(1, 0, 32'h5C, 0, 0, "miss_cycles_rd_w7");

    // make set 0 dirty with tag 1, then conflict with tag 2
    q.push_back(ev(2, 32'h04, 0, 0));
    do_req(0, 1, 32'h80, 32'h1234_5678, 5, "miss_cycles_wr_alloc");
    do_req(0, 1, 32'h84, 32'hDEADBEEF, 0, "miss_cycles_wr_hit2");
    q.push_back(ev(1, 32'h04, 32'h1234_5678, 32'hDEADBEEF));
    q.push_back(ev(2, 32'h08, 0, 0));
    q.push_back(ev(0, 0, 32'hA000_0800, 0));
    do_req(1, 0, 32'h100, 0, 9, "miss_cycles_dirty");

    // clean conflict in set 1
    q.push_back(ev(2, 32'h01, 0, 0));
    q.push_back(ev(0, 0, 32'hA000_0100, 0));
    do_req(1, 0, 32'h20, 0, 5, "miss_cycles_set1");
    q.push_back(ev(2, 32'h05, 0, 0));
    q.push_back(ev(0, 0, 32'hA000_0500, 0));
    do_req(1, 0, 32'hA0, 0, 5, "miss_cycles_clean_conflict");
    q.push_back(ev(0, 0, 32'hA000_0503, 0));
    do_req(1, 0, 32'hAC, 0, 0, "miss_cycles_rd_w3");

    // rd and wr together: store wins, rd_data held
    do_req(1, 1, 32'hAC, 32'hCAFE_F00D, 0, "miss_cycles_rdwr");
    chk("rdwr_rd_data_held", rd_data, 32'hA000_0503);
    q.push_back(ev(0, 0, 32'hCAFE_F00D, 0));
    do_req(1, 0, 32'hAC, 0, 0, "miss_cycles_rd_after_rdwr");

    // reset during write-back of dirty set 2
    gnt_dly = 100;
    q.push_back(ev(1, 32'h02, 32'hA000_0200, 32'hDEADBEEF));
    @(posedge clk); #1;
    rd_req = 1; addr = 32'h140;
    repeat (3) @(negedge clk);
    chk("swap_out_wr_req", 32'(mem_wr_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("abort_mem_wr_req", 32'(mem_wr_req), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'h0);
    rd_req = 0;
    gnt_dly = 2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    q.push_back(ev(2, 32'h02, 0, 0));
    q.push_back(ev(0, 0, 32'hA000_0201, 0));
    do_req(1, 0, 32'h44, 0, 4, "miss_cycles_after_reset");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1, "timeout");
  end
endmodule
